aes0_ct_reader: RTL and testbench
=================================

# aes0_ct_reader

Read-side companion to the AES0 plaintext/control register wrapper. Captures the 128-bit ciphertext when the AES core asserts its result-valid pulse, exposes it as four 32-bit read-only bus words, and zeroizes the holding registers once every word has been read, a new operation starts, or a hold timeout expires. No ciphertext remains readable by a later bus master after the consumer is done.

## Interface
- WORD_W, 32, bus data width; fixed, ciphertext is 4*WORD_W = 128 bits
- TIMEOUT, 1024, cycles ciphertext may sit in FULL before forced zeroize; 0 disables the timeout

- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  core start pulse, same source as the wrapper's start bit
- ct_valid_i  in  1  core result valid, 1-cycle pulse
- ct_i  in  128  core ciphertext, sampled only when ct_valid_i=1
- reglk_i  in  1  read lock for the ciphertext words
- en_i  in  1  bus access enable
- we_i  in  1  bus write; this block is read-only
- addr_i  in  6  word address, same field as address[8:3]
- rdata_o  out  32  read data, registered
- rvalid_o  out  1  read data valid
- ct_ready_o  out  1  high while unread ciphertext is held (FULL)
- busy_o  out  1  high in BUSY
- zeroize_o  out  1  1-cycle pulse in the CLEAR state

## Operation
- Address map:
  - 0: status word = {26'b0, read_mask[3:0], busy, ct_ready}
  - 5: ct[127:96]
  - 6: ct[95:64]
  - 7: ct[63:32]
  - 8: ct[31:0]
  - all other addresses read 0
- Mask bits: read_mask bit k is set when word address 5+k is read.
- FSM states: IDLE, BUSY, FULL, CLEAR.
  - IDLE: start_i -> BUSY. ct_valid_i is ignored.
  - BUSY: ct_valid_i -> FULL; capture ct_i, clear read_mask and the timer. start_i alone keeps BUSY. If ct_valid_i and start_i arrive together, the capture wins.
  - FULL, in priority order: start_i -> CLEAR; the read that completes read_mask = 4'hF -> CLEAR; timer = TIMEOUT-1 -> CLEAR (only when TIMEOUT != 0). Otherwise the timer increments.
  - CLEAR: ct registers, read_mask and timer are zeroed at the exiting edge; zeroize_o = 1 for this cycle. Next state is BUSY if start_i was the cause, otherwise IDLE.
- Read rules:
  - A read is en_i=1 and we_i=0.
  - A ct-word read in FULL with reglk_i=0 returns the word and sets its mask bit.
  - With reglk_i=1, or in any state other than FULL, a ct-word read returns 0 and sets no mask bit.
  - Status reads ignore reglk_i.
  - Re-reading a word that was already read returns it again; the mask is unchanged.
- Writes (en_i=1, we_i=1) have no effect and produce no rvalid_o.
- Reset: state IDLE; ct, read_mask and timer all 0. Outputs rdata_o=0, rvalid_o=0, ct_ready_o=0, busy_o=0, zeroize_o=0. Reset asserted mid-FULL wipes the ciphertext immediately, without waiting for a clock edge.

## Timing
- Read latency is 1: a read sampled at edge N gives rdata_o/rvalid_o valid in cycle N+1. rvalid_o is a single-cycle pulse per read. rdata_o returns to 0 whenever rvalid_o=0.
- The completing read at edge N returns correct data in cycle N+1, which is also the CLEAR cycle. From edge N+2 the ct registers read 0.
- ct_ready_o rises the cycle after the ct_valid_i edge and falls when CLEAR is entered.
- busy_o and ct_ready_o are decoded from registered state; no combinational path exists from inputs to outputs.
- Timeout: entering FULL at edge E gives CLEAR at edge E+TIMEOUT if the mask is never completed.
- Back-to-back reads are allowed every cycle.

## Test plan
- start_i, then ct_valid_i with ct_i=128'h00112233_44556677_8899AABB_CCDDEEFF; read addresses 5,6,7,8 -> rdata 00112233, 44556677, 8899AABB, CCDDEEFF each 1 cycle after its read; zeroize_o pulses; a later read of address 5 -> 0.
- Capture, read 5 and 6 only, then read status -> 32'h0000000D (mask 0011, ct_ready 1); a new start_i -> CLEAR then BUSY, status -> 32'h00000002.
- reglk_i=1 while FULL: read 5..8 -> all 0, mask stays 0, ct_ready stays 1. Drop reglk_i and read -> real data.
- TIMEOUT=8: capture and never read -> zeroize_o exactly 8 cycles after entry to FULL, ct_ready_o 0; a read of 8 -> 0.
- ct_valid_i and start_i in the same BUSY cycle -> capture occurs, state FULL. ct_valid_i in IDLE -> ignored, status 0.
- Assert rst_i asynchronously mid-FULL -> ct_ready_o 0 before the next edge; all reads return 0 after deassertion; a write to address 5 gives no rvalid_o.

Source files
------------

// File: rtl/aes0_ct_reader.sv
// rtl/aes0_ct_reader.sv - AES0 ciphertext capture, read-only bus window and zeroize control
//
// Captures the 128-bit ciphertext on the core's result-valid pulse. It exposes the
// ciphertext as four read-only bus words and wipes the holding registers after
// the last word is read, when a new operation starts, or when the hold timeout expires.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   start_i             core start pulse
//   ct_valid_i, ct_i    core result-valid pulse and ciphertext
//   reglk_i             read lock for the ciphertext words
//   en_i, we_i, addr_i  bus access enable, write flag, word address
//   rdata_o, rvalid_o   registered read data and its one-cycle valid
//   ct_ready_o          unread ciphertext held (FULL)
//   busy_o              core operation in progress (BUSY)
//   zeroize_o           one-cycle pulse while the holding registers are wiped (CLEAR)

module aes0_ct_reader #(
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                ct_valid_i,
    input  logic [4*WORD_W-1:0] ct_i,
    input  logic                reglk_i,
    input  logic                en_i,
    input  logic                we_i,
    input  logic [5:0]          addr_i,
    output logic [WORD_W-1:0]   rdata_o,
    output logic                rvalid_o,
    output logic                ct_ready_o,
    output logic                busy_o,
    output logic                zeroize_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BUSY  = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;
    localparam logic [1:0] CLEAR = 2'd3;

    localparam int            TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    logic [1:0]          state;
    logic [4*WORD_W-1:0] ct_q;
    logic [3:0]          read_mask;
    logic [TW-1:0]       timer;
    logic                restart;   // CLEAR was entered because of start_i

    logic                rd;
    logic                ct_open;
    logic                ct_sel;
    logic [WORD_W-1:0]   ct_word;
    logic [3:0]          word_bit;
    logic [3:0]          mask_next;
    logic [WORD_W-1:0]   read_data;

    assign busy_o     = (state == BUSY);
    assign ct_ready_o = (state == FULL);
    assign zeroize_o  = (state == CLEAR);

    always_comb begin
        rd      = en_i && !we_i;
        ct_open = (state == FULL) && !reglk_i;
        ct_sel   = 1'b0;
        ct_word  = '0;
        word_bit = 4'b0000;
        case (addr_i)
            6'd5: begin ct_sel = 1'b1; ct_word = ct_q[4*WORD_W-1 -: WORD_W]; word_bit = 4'b0001; end
            6'd6: begin ct_sel = 1'b1; ct_word = ct_q[3*WORD_W-1 -: WORD_W]; word_bit = 4'b0010; end
            6'd7: begin ct_sel = 1'b1; ct_word = ct_q[2*WORD_W-1 -: WORD_W]; word_bit = 4'b0100; end
            6'd8: begin ct_sel = 1'b1; ct_word = ct_q[WORD_W-1:0];           word_bit = 4'b1000; end
            default: ;
        endcase

        // Only an unlocked read in FULL counts towards completing the mask.
        mask_next = read_mask;
        if (rd && ct_sel && ct_open) begin
            mask_next = read_mask | word_bit;
        end

        read_data = '0;
        if (addr_i == 6'd0) begin
            read_data = {{(WORD_W-6){1'b0}}, read_mask, busy_o, ct_ready_o};
        end else if (ct_sel && ct_open) begin
            read_data = ct_word;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
        end else begin
            rvalid_o <= rd;
            rdata_o  <= rd ? read_data : '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            ct_q      <= '0;
            read_mask <= 4'b0000;
            timer     <= '0;
            restart   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    // Capture takes precedence over a coincident start.
                    if (ct_valid_i) begin
                        ct_q      <= ct_i;
                        read_mask <= 4'b0000;
                        timer     <= '0;
                        state     <= FULL;
                    end
                end
                FULL: begin
                    read_mask <= mask_next;
                    if (start_i) begin
                        state   <= CLEAR;
                        restart <= 1'b1;
                    end else if (mask_next == 4'hF) begin
                        state   <= CLEAR;
                        restart <= 1'b0;
                    end else if ((TIMEOUT != 0) && (timer == TIMER_LAST)) begin
                        state   <= CLEAR;
                        restart <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                CLEAR: begin
                    ct_q      <= '0;
                    read_mask <= 4'b0000;
                    timer     <= '0;
                    restart   <= 1'b0;
                    state     <= restart ? BUSY : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes0_ct_reader.sv
// tb/tb_aes0_ct_reader.sv - directed self-checking bench for aes0_ct_reader

module tb_aes0_ct_reader;

    logic         clk;
    logic         rst;
    logic         start;
    logic         ct_valid;
    logic [127:0] ct;
    logic         reglk;
    logic         en;
    logic         we;
    logic [5:0]   addr;

    logic [31:0]  rdata,  rdata8;
    logic         rvalid, rvalid8;
    logic         ct_ready, ct_ready8;
    logic         busy, busy8;
    logic         zeroize, zeroize8;

    int n_checks;
    int n_fail;

    localparam logic [127:0] CT_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] CT_B = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;

    aes0_ct_reader #(.WORD_W(32), .TIMEOUT(1024)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .ct_valid_i(ct_valid), .ct_i(ct),
        .reglk_i(reglk), .en_i(en), .we_i(we), .addr_i(addr),
        .rdata_o(rdata), .rvalid_o(rvalid), .ct_ready_o(ct_ready), .busy_o(busy),
        .zeroize_o(zeroize)
    );

    aes0_ct_reader #(.WORD_W(32), .TIMEOUT(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .ct_valid_i(ct_valid), .ct_i(ct),
        .reglk_i(reglk), .en_i(en), .we_i(we), .addr_i(addr),
        .rdata_o(rdata8), .rvalid_o(rvalid8), .ct_ready_o(ct_ready8), .busy_o(busy8),
        .zeroize_o(zeroize8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [31:0] d, output logic v);
        en = 1'b1; we = 1'b0; addr = a;
        tick();
        d = rdata; v = rvalid;
        en = 1'b0; addr = 6'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_capture(input logic [127:0] v);
        ct_valid = 1'b1; ct = v; tick(); ct_valid = 1'b0; ct = '0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic v;
        do_reset();
        n_checks++; if ({rdata, rvalid, ct_ready, busy, zeroize} !== 36'h0) begin n_fail++;
            $display("FAIL reset_outputs got %h exp 0", {rdata, rvalid, ct_ready, busy, zeroize}); end
        bus_read(6'd0, d, v);
        n_checks++; if ({v, d} !== {1'b1, 32'h0}) begin n_fail++;
            $display("FAIL reset_status got v=%b d=%h exp v=1 d=0", v, d); end
    endtask

    task automatic test_full_read();
        logic [31:0] d; logic v;
        pulse_start();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_start got %b exp 1", busy); end
        pulse_capture(CT_A);
        n_checks++; if ({ct_ready, busy} !== 2'b10) begin n_fail++;
            $display("FAIL ct_ready_after_capture got %b exp 10", {ct_ready, busy}); end
        bus_read(6'd5, d, v);
        n_checks++; if ({v, d} !== {1'b1, 32'h00112233}) begin n_fail++; $display("FAIL word5 got %b %h exp 1 00112233", v, d); end
        bus_read(6'd6, d, v);
        n_checks++; if ({v, d} !== {1'b1, 32'h44556677}) begin n_fail++; $display("FAIL word6 got %b %h exp 1 44556677", v, d); end
        bus_read(6'd7, d, v);
        n_checks++; if ({v, d} !== {1'b1, 32'h8899AABB}) begin n_fail++; $display("FAIL word7 got %b %h exp 1 8899AABB", v, d); end
        bus_read(6'd8, d, v);
        n_checks++; if ({v, d} !== {1'b1, 32'hCCDDEEFF}) begin n_fail++; $display("FAIL word8 got %b %h exp 1 CCDDEEFF", v, d); end
        n_checks++; if ({zeroize, ct_ready} !== 2'b10) begin n_fail++;
            $display("FAIL zeroize_on_complete got %b exp 10", {zeroize, ct_ready}); end
        tick();
        n_checks++; if ({zeroize, rvalid, rdata} !== {2'b00, 32'h0}) begin n_fail++;
            $display("FAIL after_clear got z=%b v=%b d=%h exp 0 0 0", zeroize, rvalid, rdata); end
        bus_read(6'd5, d, v);
        n_checks++; if ({v, d} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL word5_after_zeroize got %b %h exp 1 0", v, d); end
    endtask

    task automatic test_partial_then_start();
        logic [31:0] d; logic v;
        pulse_start();
        pulse_capture(CT_A);
        bus_read(6'd5, d, v);
        bus_read(6'd6, d, v);
        bus_read(6'd0, d, v);
        n_checks++; if (d !== 32'h0000000D) begin n_fail++; $display("FAIL partial_status got %h exp 0000000D", d); end
        start = 1'b1; tick(); start = 1'b0;
        n_checks++; if ({zeroize, ct_ready} !== 2'b10) begin n_fail++; $display("FAIL start_clear got %b exp 10", {zeroize, ct_ready}); end
        tick();
        n_checks++; if ({zeroize, busy} !== 2'b01) begin n_fail++; $display("FAIL clear_to_busy got %b exp 01", {zeroize, busy}); end
        bus_read(6'd0, d, v);
        n_checks++; if (d !== 32'h00000002) begin n_fail++; $display("FAIL status_busy got %h exp 00000002", d); end
    endtask

    task automatic test_reglk();
        logic [31:0] d; logic v;
        pulse_capture(CT_B);   // still BUSY from previous test
        reglk = 1'b1;
        for (int k = 5; k <= 8; k++) begin
            bus_read(6'(k), d, v);
            n_checks++; if ({v, d} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL locked_word%0d got %b %h exp 1 0", k, v, d); end
        end
        bus_read(6'd0, d, v);
        n_checks++; if (d !== 32'h00000001) begin n_fail++; $display("FAIL locked_status got %h exp 00000001", d); end
        reglk = 1'b0;
        bus_read(6'd5, d, v);
        n_checks++; if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL unlocked_word5 got %h exp DEADBEEF", d); end
        bus_read(6'd5, d, v);
        n_checks++; if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL reread_word5 got %h exp DEADBEEF", d); end
        bus_read(6'd0, d, v);
        n_checks++; if (d !== 32'h00000005) begin n_fail++; $display("FAIL reread_status got %h exp 00000005", d); end
        bus_read(6'd6, d, v);
        bus_read(6'd7, d, v);
        n_checks++; if (d !== 32'h89ABCDEF) begin n_fail++; $display("FAIL unlocked_word7 got %h exp 89ABCDEF", d); end
        bus_read(6'd8, d, v);
        n_checks++; if ({d, zeroize} !== {32'hFEDCBA98, 1'b1}) begin n_fail++;
            $display("FAIL last_word_clear got %h z=%b exp FEDCBA98 z=1", d, zeroize); end
        tick();
    endtask

    task automatic test_timeout();
        logic [31:0] d; logic v;
        do_reset();
        pulse_start();
        pulse_capture(CT_A);   // FULL entered at edge E
        repeat (7) tick();
        n_checks++; if ({zeroize8, ct_ready8} !== 2'b01) begin n_fail++;
            $display("FAIL timeout_early got %b exp 01", {zeroize8, ct_ready8}); end
        tick();
        n_checks++; if ({zeroize8, ct_ready8} !== 2'b10) begin n_fail++;
            $display("FAIL timeout_fire got %b exp 10", {zeroize8, ct_ready8}); end
        n_checks++; if ({zeroize, ct_ready} !== 2'b01) begin n_fail++;
            $display("FAIL long_timeout_holds got %b exp 01", {zeroize, ct_ready}); end
        tick();
        bus_read(6'd8, d, v);
        n_checks++; if ({rvalid8, rdata8} !== {1'b1, 32'h0}) begin n_fail++;
            $display("FAIL timeout_word8 got %b %h exp 1 0", rvalid8, rdata8); end
    endtask

    task automatic test_back_to_back_events();
        logic [31:0] d; logic v;
        do_reset();
        pulse_capture(CT_A);   // IDLE: ignored
        n_checks++; if ({ct_ready, busy} !== 2'b00) begin n_fail++; $display("FAIL idle_capture got %b exp 00", {ct_ready, busy}); end
        bus_read(6'd0, d, v);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL idle_status got %h exp 0", d); end
        pulse_start();
        start = 1'b1; ct_valid = 1'b1; ct = CT_B; tick();
        start = 1'b0; ct_valid = 1'b0; ct = '0;
        n_checks++; if ({ct_ready, busy} !== 2'b10) begin n_fail++; $display("FAIL capture_wins got %b exp 10", {ct_ready, busy}); end
        bus_read(6'd6, d, v);
        n_checks++; if (d !== 32'h01234567) begin n_fail++; $display("FAIL capture_wins_word6 got %h exp 01234567", d); end
    endtask

    task automatic test_async_reset();
        logic [31:0] d; logic v;
        #3;
        rst = 1'b1;
        #1;
        n_checks++; if ({ct_ready, busy, zeroize} !== 3'b000) begin n_fail++;
            $display("FAIL async_reset got %b exp 000", {ct_ready, busy, zeroize}); end
        tick();
        rst = 1'b0;
        tick();
        for (int k = 5; k <= 8; k++) begin
            bus_read(6'(k), d, v);
            n_checks++; if ({v, d} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL post_reset_word%0d got %b %h exp 1 0", k, v, d); end
        end
        en = 1'b1; we = 1'b1; addr = 6'd5; tick();
        en = 1'b0; we = 1'b0; addr = 6'd0;
        n_checks++; if ({rvalid, rdata} !== {1'b0, 32'h0}) begin n_fail++;
            $display("FAIL write_no_rvalid got %b %h exp 0 0", rvalid, rdata); end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1'b0; start = 1'b0; ct_valid = 1'b0; ct = '0;
        reglk = 1'b0; en = 1'b0; we = 1'b0; addr = 6'd0;
        test_reset();
        test_full_read();
        test_partial_then_start();
        test_reglk();
        test_timeout();
        test_back_to_back_events();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
